// File: rtl/spi_target.sv
`default_nettype none
// spi_target: mode-0 SPI responder. The pad inputs are oversampled on clk_i,
// received bytes go into an RX FIFO and transmitted bytes come from a TX FIFO.
module spi_target #(
  parameter int         RxDepth    = 4,
  parameter int         TxDepth    = 4,
  parameter logic [7:0] TxIdleByte = 8'hFF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cio_sck_i,
  input  logic                       cio_csb_i,
  input  logic                       cio_sd_i,
  output logic                       cio_sd_o,
  output logic                       cio_sd_en_o,
  input  logic [7:0]                 tx_data_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  output logic [7:0]                 rx_data_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output logic [$clog2(TxDepth):0]   tx_level_o,
  output logic [$clog2(RxDepth):0]   rx_level_o,
  output logic                       busy_o,
  output logic                       rx_overflow_o,
  output logic                       tx_underflow_o,
  output logic                       abort_o
);
  localparam int TW = $clog2(TxDepth) + 1;
  localparam int RW = $clog2(RxDepth) + 1;
  localparam logic [TW-1:0] TxFull = TW'(TxDepth);
  localparam logic [RW-1:0] RxFull = RW'(RxDepth);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic sck_q1, sck_q2, sck_d, csb_q1, csb_q2, csb_d, sd_q1, sd_q2;
  logic [1:0] flush;
  logic armed;
  logic [7:0] tx_shift, rx_shift;
  logic [2:0] bit_cnt;
  logic byte_done;
  logic [7:0] tx_mem [TxDepth];
  logic [7:0] rx_mem [RxDepth];
  logic [TW-1:0] tx_wr, tx_rd;
  logic [RW-1:0] rx_wr, rx_rd;

  logic sck_rise, sck_fall, csb_fall, csb_rise;
  logic start_frame, end_frame, tx_load, tx_shift_en, rx_bit;
  logic tx_empty, tx_push, tx_pop, rx_full, rx_complete, rx_pop, rx_push, rx_drop;
  logic [7:0] rx_byte;

  // A CSB fall only counts once CSB has been seen high after the synchronizer
  // has flushed, so a host still mid-frame across a reset is ignored.
  assign sck_rise = sck_q2 & ~sck_d;
  assign sck_fall = ~sck_q2 & sck_d;
  assign csb_fall = armed & csb_d & ~csb_q2;
  assign csb_rise = csb_q2 & ~csb_d;

  assign tx_level_o  = tx_wr - tx_rd;
  assign rx_level_o  = rx_wr - rx_rd;
  assign tx_empty    = (tx_level_o == '0);
  assign tx_ready_o  = (tx_level_o != TxFull);
  assign tx_push     = tx_valid_i & tx_ready_o;
  assign tx_pop      = tx_load & ~tx_empty;
  assign rx_full     = (rx_level_o == RxFull);
  assign rx_valid_o  = (rx_level_o != '0);
  assign rx_data_o   = rx_mem[rx_rd[RW-2:0]];
  assign rx_pop      = rx_valid_o & rx_ready_i;
  assign rx_byte     = {rx_shift[6:0], sd_q2};
  assign rx_complete = rx_bit & (bit_cnt == 3'd7);
  assign rx_push     = rx_complete & (~rx_full | rx_pop);
  assign rx_drop     = rx_complete & rx_full & ~rx_pop;
  assign cio_sd_o    = tx_shift[7];
  assign busy_o      = (state == ACTIVE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    rx_bit      = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
          tx_load     = 1'b1;
        end
      end
      ACTIVE: begin
        if (csb_rise) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else if (sck_rise) begin
          rx_bit = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt == 3'd0 && byte_done) tx_load = 1'b1;
          else                              tx_shift_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {sck_q1, sck_q2, sck_d} <= 3'b000;
      {csb_q1, csb_q2, csb_d} <= 3'b111;
      {sd_q1, sd_q2}          <= 2'b00;
      flush          <= 2'b00;
      armed          <= 1'b0;
      tx_shift       <= 8'h00;
      rx_shift       <= 8'h00;
      bit_cnt        <= 3'd0;
      byte_done      <= 1'b0;
      cio_sd_en_o    <= 1'b0;
      rx_overflow_o  <= 1'b0;
      tx_underflow_o <= 1'b0;
      abort_o        <= 1'b0;
      tx_wr          <= '0;
      tx_rd          <= '0;
      rx_wr          <= '0;
      rx_rd          <= '0;
      for (int i = 0; i < TxDepth; i++) tx_mem[i] <= 8'h00;
      for (int i = 0; i < RxDepth; i++) rx_mem[i] <= 8'h00;
    end else begin
      sck_q1 <= cio_sck_i; sck_q2 <= sck_q1; sck_d <= sck_q2;
      csb_q1 <= cio_csb_i; csb_q2 <= csb_q1; csb_d <= csb_q2;
      sd_q1  <= cio_sd_i;  sd_q2  <= sd_q1;
      flush  <= {flush[0], 1'b1};
      armed  <= armed | (flush[1] & csb_q2);

      tx_underflow_o <= tx_load & tx_empty;
      rx_overflow_o  <= rx_drop;
      abort_o        <= end_frame & (bit_cnt != 3'd0);

      if (tx_load)          tx_shift <= tx_empty ? TxIdleByte : tx_mem[tx_rd[TW-2:0]];
      else if (tx_shift_en) tx_shift <= {tx_shift[6:0], 1'b0};

      if (start_frame) begin
        bit_cnt     <= 3'd0;
        byte_done   <= 1'b0;
        cio_sd_en_o <= 1'b1;
      end
      if (end_frame) cio_sd_en_o <= 1'b0;
      if (rx_bit) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end

      if (tx_push) begin
        tx_mem[tx_wr[TW-2:0]] <= tx_data_i;
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      if (rx_push) begin
        rx_mem[rx_wr[RW-2:0]] <= rx_byte;
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
    end
  end
endmodule
`default_nettype wire
